// File: rtl/data_mem_resp.sv
// rtl/data_mem_resp.sv - multi-cycle data-memory responder with stall return
module data_mem_resp #(
    parameter int WORD_DEPTH = 32,
    parameter int LATENCY    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] offset,
    input  logic        mem_cen,
    input  logic        mem_wen,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_stall,
    output logic        mem_err
);

    localparam int IW = (WORD_DEPTH > 1) ? $clog2(WORD_DEPTH) : 1;

    generate
        if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
            $error("data_mem_resp: LATENCY must be in 1..15");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        lat_wen;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;

    logic [31:0] mem [0:WORD_DEPTH-1];

    logic        acc_wen;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;
    logic [31:0] acc_idx;
    logic [IW-1:0] acc_slot;
    logic        acc_legal;
    logic        enter_resp;

    // Access operands: taken straight from the port when IDLE jumps to RESP (LATENCY==1), else the latched copy
    always_comb begin
        acc_wen   = lat_wen;
        acc_addr  = lat_addr;
        acc_wdata = lat_wdata;
        if (state == IDLE) begin
            acc_wen   = mem_wen;
            acc_addr  = mem_addr;
            acc_wdata = mem_wdata;
        end
        acc_idx    = (acc_addr - offset) >> 2;
        acc_slot   = acc_idx[IW-1:0];
        acc_legal  = (acc_addr >= offset) && (acc_idx < 32'(WORD_DEPTH)) && (acc_addr[1:0] == 2'b00);
        enter_resp = ((state == IDLE) && mem_cen && (LATENCY == 1)) ||
                     ((state == WAIT) && (cnt == 4'd1));
    end

    // Stall is combinational so CHIP sees it in the same cycle the request appears
    assign mem_stall = mem_cen & (state != RESP);

    // Control FSM with latched request, registered read data and sticky error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            lat_wen   <= 1'b0;
            lat_addr  <= 32'h0;
            lat_wdata <= 32'h0;
            mem_rdata <= 32'h0;
            mem_err   <= 1'b0;
        end else begin
            if (enter_resp && !acc_wen) begin
                mem_rdata <= acc_legal ? mem[acc_slot] : 32'h0;
            end else if (enter_resp && !acc_legal) begin
                mem_rdata <= 32'h0;
            end
            if (enter_resp && !acc_legal) begin
                mem_err <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (mem_cen) begin
                        lat_wen   <= mem_wen;
                        lat_addr  <= mem_addr;
                        lat_wdata <= mem_wdata;
                        if (LATENCY == 1) begin
                            state <= RESP;
                        end else begin
                            cnt   <= 4'(LATENCY - 1);
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 4'd1) begin
                        cnt   <= 4'd0;
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Storage array: cleared on reset, written on the edge entering RESP for legal writes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WORD_DEPTH; i++) begin
                mem[i] <= 32'h0;
            end
        end else if (enter_resp && acc_wen && acc_legal) begin
            mem[acc_slot] <= acc_wdata;
        end
    end

endmodule
